// File: rtl/level_ctrl_if.sv
// rtl/level_ctrl_if.sv - game-progression controller signal bundle
interface level_ctrl_if;
    logic       start_btn;
    logic       frame_tick;
    logic       all_collected;
    logic       crash;
    logic [1:0] level_id;
    logic       flag_clr;
    logic       player_rst;
    logic [1:0] lives;
    logic       banner;
    logic       game_won;
    logic       game_over;
    logic       playing;

    modport master (
        input  start_btn, frame_tick, all_collected, crash,
        output level_id, flag_clr, player_rst, lives,
        output banner, game_won, game_over, playing
    );

    modport slave (
        output start_btn, frame_tick, all_collected, crash,
        input  level_id, flag_clr, player_rst, lives,
        input  banner, game_won, game_over, playing
    );
endinterface

// File: rtl/level_ctrl.sv
// rtl/level_ctrl.sv - start/level/clear/win/over sequencer feeding the flag stage
module level_ctrl #(
    parameter int NUM_LEVELS    = 3,
    parameter int LIVES_INIT    = 3,
    parameter int BANNER_FRAMES = 120,
    parameter int GUARD_CYCLES  = 2
) (
    input  logic         clk,
    input  logic         rst,
    level_ctrl_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_PLAY, S_CLEAR, S_WIN, S_OVER} state_t;

    localparam logic [1:0] LAST_LEVEL = 2'(NUM_LEVELS);
    localparam logic [1:0] LIVES_LOAD = 2'(LIVES_INIT);
    localparam logic [7:0] BANNER_LD  = 8'(BANNER_FRAMES);
    localparam logic [3:0] GUARD_LD   = 4'(GUARD_CYCLES);

    state_t     state;
    logic       start_prev;
    logic       start_edge;
    logic [3:0] guard;
    logic [7:0] banner_cnt;

    assign start_edge = bus.start_btn & ~start_prev;

    // {playing, banner, game_won, game_over}; IDLE has none set
    function automatic logic [3:0] status(state_t s);
        case (s)
            S_PLAY:  return 4'b1000;
            S_CLEAR: return 4'b0100;
            S_WIN:   return 4'b0010;
            S_OVER:  return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            bus.level_id   <= 2'd0;
            bus.lives      <= LIVES_LOAD;
            bus.flag_clr   <= 1'b1;
            bus.player_rst <= 1'b1;
            start_prev     <= 1'b1;
            guard          <= 4'd0;
            banner_cnt     <= 8'd0;
            {bus.playing, bus.banner, bus.game_won, bus.game_over} <= 4'b0000;
        end else begin
            start_prev     <= bus.start_btn;
            bus.flag_clr   <= 1'b0;
            bus.player_rst <= 1'b0;
            case (state)
                S_IDLE, S_WIN, S_OVER: begin
                    if (start_edge) begin
                        state          <= S_PLAY;
                        bus.level_id   <= 2'd1;
                        bus.lives      <= LIVES_LOAD;
                        bus.flag_clr   <= 1'b1;
                        bus.player_rst <= 1'b1;
                        guard          <= GUARD_LD;
                        {bus.playing, bus.banner, bus.game_won, bus.game_over} <= status(S_PLAY);
                    end
                end
                S_PLAY: begin
                    if (guard != 4'd0)
                        guard <= guard - 4'd1;
                    // the guard hides the stale all_collected until the flag stage has seen flag_clr
                    if (guard == 4'd0 && bus.all_collected) begin
                        state      <= S_CLEAR;
                        banner_cnt <= BANNER_LD;
                        {bus.playing, bus.banner, bus.game_won, bus.game_over} <= status(S_CLEAR);
                    end else if (bus.crash) begin
                        if (bus.lives > 2'd1) begin
                            bus.lives      <= bus.lives - 2'd1;
                            bus.player_rst <= 1'b1;
                        end else begin
                            bus.lives    <= 2'd0;
                            bus.level_id <= 2'd0;
                            state        <= S_OVER;
                            {bus.playing, bus.banner, bus.game_won, bus.game_over} <= status(S_OVER);
                        end
                    end
                end
                S_CLEAR: begin
                    if (bus.frame_tick) begin
                        if (banner_cnt <= 8'd1) begin
                            if (bus.level_id >= LAST_LEVEL) begin
                                state        <= S_WIN;
                                bus.level_id <= 2'd0;
                                {bus.playing, bus.banner, bus.game_won, bus.game_over} <= status(S_WIN);
                            end else begin
                                state          <= S_PLAY;
                                bus.level_id   <= bus.level_id + 2'd1;
                                bus.flag_clr   <= 1'b1;
                                bus.player_rst <= 1'b1;
                                guard          <= GUARD_LD;
                                {bus.playing, bus.banner, bus.game_won, bus.game_over} <= status(S_PLAY);
                            end
                        end else begin
                            banner_cnt <= banner_cnt - 8'd1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    {bus.playing, bus.banner, bus.game_won, bus.game_over} <= status(S_IDLE);
                end
            endcase
        end
    end
endmodule

// File: tb/tb_level_ctrl.sv
// tb/tb_level_ctrl.sv - scoreboard bench for level_ctrl
module tb_level_ctrl;
    localparam logic [3:0] ST_IDLE = 4'b0000;
    localparam logic [3:0] ST_PLAY = 4'b1000;
    localparam logic [3:0] ST_CLR  = 4'b0100;
    localparam logic [3:0] ST_WIN  = 4'b0010;
    localparam logic [3:0] ST_OVER = 4'b0001;

    typedef struct {
        string       name;
        int          cyc;
        logic [1:0]  level_id;
        logic [1:0]  lives;
        logic        flag_clr;
        logic        player_rst;
        logic [3:0]  st;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t e;

    level_ctrl_if bus();

    level_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: pops every expectation stamped for the current cycle
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_checks++;
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: stale expectation for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
            end else if (bus.level_id !== e.level_id || bus.lives !== e.lives ||
                         bus.flag_clr !== e.flag_clr || bus.player_rst !== e.player_rst ||
                         {bus.playing, bus.banner, bus.game_won, bus.game_over} !== e.st) begin
                n_fail++;
                $display("FAIL %s: got level=%0d lives=%0d flag_clr=%b player_rst=%b pbwo=%b, expected level=%0d lives=%0d flag_clr=%b player_rst=%b pbwo=%b",
                         e.name, bus.level_id, bus.lives, bus.flag_clr, bus.player_rst,
                         {bus.playing, bus.banner, bus.game_won, bus.game_over},
                         e.level_id, e.lives, e.flag_clr, e.player_rst, e.st);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [1:0] lvl, input logic [1:0] lv,
                       input logic fc, input logic pr, input logic [3:0] st);
        exp_t x;
        x.name = nm; x.cyc = cyc; x.level_id = lvl; x.lives = lv;
        x.flag_clr = fc; x.player_rst = pr; x.st = st;
        sb.push_back(x);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.frame_tick = 1'b1; step();
            bus.frame_tick = 1'b0; step();
        end
    endtask

    // wait out the guard, collect all flags, then sit through the full banner
    task automatic clear_level();
        step(); step();
        bus.all_collected = 1'b1; step();
        bus.all_collected = 1'b0;
        ticks(119);
        bus.frame_tick = 1'b1; step();
        bus.frame_tick = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected stimulus to complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.start_btn = 1'b1;
        bus.frame_tick = 1'b0;
        bus.all_collected = 1'b0;
        bus.crash = 1'b0;

        // reset with button held; no start until a fresh rising edge
        step(); step();
        chk("reset", 2'd0, 2'd3, 1'b1, 1'b1, ST_IDLE);
        rst = 1'b0; step();
        chk("reset_release", 2'd0, 2'd3, 1'b0, 1'b0, ST_IDLE);
        step(); step();
        chk("held_btn_no_start", 2'd0, 2'd3, 1'b0, 1'b0, ST_IDLE);
        bus.start_btn = 1'b0; step();
        bus.start_btn = 1'b1; step();
        chk("start", 2'd1, 2'd3, 1'b1, 1'b1, ST_PLAY);
        bus.start_btn = 1'b0;

        // guard window hides all_collected for two cycles
        bus.all_collected = 1'b1; step();
        chk("guard_1", 2'd1, 2'd3, 1'b0, 1'b0, ST_PLAY);
        step();
        chk("guard_2", 2'd1, 2'd3, 1'b0, 1'b0, ST_PLAY);
        step();
        chk("l1_clear", 2'd1, 2'd3, 1'b0, 1'b0, ST_CLR);
        bus.all_collected = 1'b0;
        ticks(119);
        chk("banner_after_119", 2'd1, 2'd3, 1'b0, 1'b0, ST_CLR);
        bus.frame_tick = 1'b1; step();
        chk("l2_enter", 2'd2, 2'd3, 1'b1, 1'b1, ST_PLAY);
        bus.frame_tick = 1'b0;

        // crashes in L2
        step(); step();
        bus.crash = 1'b1; step(); bus.crash = 1'b0;
        chk("crash1", 2'd2, 2'd2, 1'b0, 1'b1, ST_PLAY);
        step();
        chk("crash1_pulse_end", 2'd2, 2'd2, 1'b0, 1'b0, ST_PLAY);
        bus.crash = 1'b1; step(); bus.crash = 1'b0;
        chk("crash2", 2'd2, 2'd1, 1'b0, 1'b1, ST_PLAY);
        bus.crash = 1'b1; step(); bus.crash = 1'b0;
        chk("crash3_over", 2'd0, 2'd0, 1'b0, 1'b0, ST_OVER);
        bus.crash = 1'b1; step(); bus.crash = 1'b0;
        chk("over_ignores_crash", 2'd0, 2'd0, 1'b0, 1'b0, ST_OVER);

        // full run to WIN
        bus.start_btn = 1'b1; step(); bus.start_btn = 1'b0;
        chk("restart", 2'd1, 2'd3, 1'b1, 1'b1, ST_PLAY);
        clear_level();
        chk("to_l2", 2'd2, 2'd3, 1'b1, 1'b1, ST_PLAY);
        clear_level();
        chk("to_l3", 2'd3, 2'd3, 1'b1, 1'b1, ST_PLAY);
        step(); step();
        bus.all_collected = 1'b1; step(); bus.all_collected = 1'b0;
        chk("l3_clear", 2'd3, 2'd3, 1'b0, 1'b0, ST_CLR);
        ticks(119);
        bus.frame_tick = 1'b1; step(); bus.frame_tick = 1'b0;
        chk("win", 2'd0, 2'd3, 1'b0, 1'b0, ST_WIN);
        bus.crash = 1'b1; bus.all_collected = 1'b1; step();
        bus.crash = 1'b0; bus.all_collected = 1'b0;
        chk("win_ignores_inputs", 2'd0, 2'd3, 1'b0, 1'b0, ST_WIN);
        bus.start_btn = 1'b1; step(); bus.start_btn = 1'b0;
        chk("win_restart", 2'd1, 2'd3, 1'b1, 1'b1, ST_PLAY);

        // crash honoured in guard; all_collected beats simultaneous crash
        bus.crash = 1'b1; step(); bus.crash = 1'b0;
        chk("guard_crash", 2'd1, 2'd2, 1'b0, 1'b1, ST_PLAY);
        step();
        bus.crash = 1'b1; step(); bus.crash = 1'b0;
        chk("crash_to_one", 2'd1, 2'd1, 1'b0, 1'b1, ST_PLAY);
        bus.crash = 1'b1; bus.all_collected = 1'b1; step();
        bus.crash = 1'b0; bus.all_collected = 1'b0;
        chk("collect_beats_crash", 2'd1, 2'd1, 1'b0, 1'b0, ST_CLR);
        bus.crash = 1'b1; step(); bus.crash = 1'b0;
        chk("clear_ignores_crash", 2'd1, 2'd1, 1'b0, 1'b0, ST_CLR);
        bus.start_btn = 1'b1; step(); bus.start_btn = 1'b0;
        chk("clear_ignores_start", 2'd1, 2'd1, 1'b0, 1'b0, ST_CLR);

        // reset mid-banner with counter at 57
        ticks(63);
        chk("banner_at_57", 2'd1, 2'd1, 1'b0, 1'b0, ST_CLR);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_mid_clear", 2'd0, 2'd3, 1'b1, 1'b1, ST_IDLE);
        step();
        chk("after_rst", 2'd0, 2'd3, 1'b0, 1'b0, ST_IDLE);
        ticks(130);
        chk("idle_ignores_ticks", 2'd0, 2'd3, 1'b0, 1'b0, ST_IDLE);

        step(); step();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/level_ctrl.md
Name: level_ctrl

Overview:
Game-progression controller that sits directly upstream of the flag collection/drawing stage. It drives level_id and a synchronous flag clear into that stage, and consumes its all_collected output. It sequences start → level 1..NUM_LEVELS → win, and handles crash/lives, a between-level banner timed in video frames, and player respawn pulses for the movement stage.

Parameters:
NUM_LEVELS, 3, last playable level; 1..3, since level_id is 2 bits and 0 means "no level".
LIVES_INIT, 3, lives loaded on game start; 1..3.
BANNER_FRAMES, 120, frame_tick pulses spent in CLEAR before the next level; 1..255.
GUARD_CYCLES, 2, clk cycles after entering PLAY during which all_collected is ignored; 1..15.

Ports:
clk  in  1  system clock (single clock domain)
rst  in  1  synchronous, active-high reset
start_btn  in  1  start button, already debounced; level-sensitive, rising edge used
frame_tick  in  1  one-cycle pulse per video frame
all_collected  in  1  from flag stage: every active flag of the current level is collected
crash  in  1  one-cycle pulse: player hit a wall or an enemy
level_id  out  2  current level to the flag stage; 0 when no level is active
flag_clr  out  1  one-cycle pulse into the flag stage rst (clears collected)
player_rst  out  1  one-cycle pulse: respawn player at the level start position
lives  out  2  remaining lives
banner  out  1  high in CLEAR ("LEVEL CLEAR" overlay)
game_won  out  1  high in WIN
game_over  out  1  high in OVER
playing  out  1  high in PLAY

Behaviour:
- One clock, clk; rst is synchronous and active-high. All outputs are registered.
- Values on rst:
  - state=IDLE, level_id=0, lives=LIVES_INIT.
  - banner, game_won, game_over, playing = 0.
  - flag_clr=1 and player_rst=1 for the cycle after the reset edge, then 0.
  - start_prev=1, so a button held through reset does not start a game.
- start_edge = start_btn & ~start_prev; start_prev is registered every cycle.
- States: IDLE, PLAY, CLEAR, WIN, OVER.
- IDLE / WIN / OVER:
  - level_id=0.
  - On start_edge: go to PLAY with level_id=1 and lives=LIVES_INIT. Pulse flag_clr and player_rst for 1 cycle, registered with the transition.
  - crash, all_collected and frame_tick are ignored.
- PLAY entry: guard counter loaded with GUARD_CYCLES, decremented each cycle to 0. While guard≠0, all_collected is ignored. This covers the one-cycle lag before the flag stage sees flag_clr.
- PLAY with guard=0 and all_collected=1:
  - Go to CLEAR; level_id is held; banner counter loaded with BANNER_FRAMES.
  - all_collected takes priority over a crash in the same cycle; that crash is discarded and lives are unchanged.
- PLAY with crash=1 (and no qualifying all_collected):
  - lives>1: lives-=1, pulse player_rst, stay in PLAY. No flag_clr; collected flags are kept.
  - lives==1: lives=0, go to OVER, level_id=0.
- crash is honoured during the guard window.
- CLEAR:
  - Each frame_tick decrements the banner counter.
  - On a frame_tick with counter==1:
    - level_id==NUM_LEVELS: go to WIN, level_id=0.
    - Otherwise: level_id+=1, go to PLAY (guard reloaded), pulse flag_clr and player_rst.
  - crash is ignored; start_edge is ignored.
- Status flags are decoded from the next state, so they change on the same edge as state. Exactly one of playing/banner/game_won/game_over is high, except in IDLE, where all are 0.
- Transition latency: 1 clk from the qualifying input sample to the new state and outputs.
- lives never underflows and never exceeds LIVES_INIT; level_id never exceeds NUM_LEVELS.
- rst asserted in any state, mid-banner or mid-pulse, returns to the reset values on the next edge. Pending pulses are dropped, except flag_clr and player_rst, which re-assert as per reset.

Test Plan:
1. rst 2 cycles with start_btn held high → IDLE, level_id=0, lives=3. No start until start_btn falls and rises again; on that edge level_id=1, playing=1, 1-cycle flag_clr and player_rst.
2. PLAY L1, all_collected=1 during the first 2 cycles after entry → ignored. Held at cycle 3 → banner=1, level_id=1. After 120 frame_ticks → level_id=2, flag_clr pulse, playing=1.
3. L3 cleared, 120 frame_ticks → game_won=1, level_id=0. start_edge → level_id=1, lives=3.
4. Three crash pulses in PLAY L2 → lives 3→2→1, player_rst pulses after the first two, no flag_clr. Third crash → game_over=1, lives=0, level_id=0.
5. crash and all_collected in the same cycle, guard expired, lives=1 → CLEAR, lives stays 1.
6. rst asserted mid-CLEAR (counter=57) → IDLE, banner=0, level_id=0, flag_clr pulse. frame_ticks ignored afterwards.
